mul_seq: RTL

- Sequencer for a radix-2 iterative shift-add multiplier that executes the pipeline's `mul` instruction in the EX stage.
- Accepts an issue from the EX stage and holds the pipeline with `stall_o` while iterating.
- Returns the low WORD_W bits of the product with a one-cycle `done_o` pulse.
- Sits beside the ALU and feeds the hazard/stall logic and the EX/MEM result mux.

---
 rtl/mul_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mul_seq.sv
// ============================================================================
// mul_seq : radix-2 shift-add multiplier sequencer for the EX-stage `mul`.
// Optional build macro: MUL_EARLY_EXIT_EN (stop once the multiplier runs out).
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_seq #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [WORD_W-1:0] op_a_i,
    input  logic [WORD_W-1:0] op_b_i,
    input  logic [4:0]        rd_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [WORD_W-1:0] result_o,
    output logic [4:0]        rd_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WORD_W-1:0] mcand_q;
    logic [WORD_W-1:0] mplier_q;
    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] result_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [4:0]        rd_q;
    logic              busy_q;
    logic              done_q;

    logic              accept_d;
    logic [WORD_W-1:0] acc_d;
    logic [WORD_W-1:0] mplier_d;
    logic              last_d;

    // rst_i gates accept so stall_o stays low while reset is held
    assign accept_d = rst_i && (state_q == S_IDLE) && start_i && valid_i && !flush_i;

    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
        mplier_d = mplier_q >> 1;
        last_d   = (cnt_q == CNT_W'(WORD_W - 1));
`ifdef MUL_EARLY_EXIT_EN
        last_d   = last_d || (mplier_d == '0);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (accept_d) begin
                        mcand_q  <= op_a_i;
                        mplier_q <= op_b_i;
                        rd_q     <= rd_i;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (flush_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (start_i) begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_d;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (last_d) begin
                            result_q <= acc_d;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_o  = accept_d || (state_q == S_BUSY);
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign rd_o     = rd_q;

endmodule

`default_nettype wire
